coin_payer: RTL and testbench
=============================

Name: coin_payer

Overview:
- Customer-side driver for the cola vending FSM; it inserts coins into that FSM.
- Accepts a "buy one cola" request carrying a wallet: counts of 1-yuan and 0.5-yuan coins.
- Emits single-cycle pi_money_one / pi_money_half pulses until the price is covered, then watches po_cola / po_money for the outcome.
- Used as the bench/system-side initiator of the vending interface.

Parameters:
- PRICE_HALF, 5, price in half-yuan units (5 = 2.5 yuan); legal range 1..15.
- GAP_CYC, 2, idle cycles between coin pulses; legal range 1..15.
- TIMEOUT_CYC, 8, cycles to wait for po_cola after the final coin; legal range 2..255.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  purchase request.
- req_ready  out  1  high only in IDLE.
- req_one_num  in  3  1-yuan coins available.
- req_half_num  in  3  half-yuan coins available.
- po_cola  in  1  cola pulse from the vending FSM.
- po_money  in  1  change pulse from the vending FSM.
- pi_money_one  out  1  1-yuan coin pulse to the vending FSM.
- pi_money_half  out  1  half-yuan coin pulse to the vending FSM.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  2  00 ok, 01 insufficient funds, 10 timeout, 11 change mismatch.
- resp_used_one  out  3  1-yuan coins spent.
- resp_used_half  out  3  half-yuan coins spent.

Behaviour:
- Reset: all outputs 0, except req_ready = 1. FSM goes to IDLE; all counters clear.
- Reset asserted mid-purchase aborts immediately. No resp_valid is produced.
- Handshake: request accepted when req_valid && req_ready. req_one_num and req_half_num are latched on that edge. req_ready is 0 from the next cycle until the cycle after resp_valid.
- State IDLE: on accept, latch the wallet, set owed R = PRICE_HALF, go to CHECK.
  - R is 5-bit signed.
- State CHECK (1 cycle):
  - If 2*one + half < PRICE_HALF: go to DONE with err 01. No coins are issued.
  - Otherwise go to INSERT.
- State INSERT (1 cycle): drive exactly one coin pulse, chosen in priority order:
  - R >= 2 and one left: pi_money_one, R -= 2.
  - Else if half left: pi_money_half, R -= 1.
  - Else: pi_money_one, R -= 2. This overpays; change is expected.
  - In all cases decrement the used wallet count and increment resp_used_*.
  - The two coin outputs are never high together.
- After INSERT:
  - If R <= 0: go to WAIT_COLA. Latch chg_exp = (R < 0).
  - Else go to GAP.
- State GAP: hold for GAP_CYC cycles with both coin outputs 0, then go to INSERT.
  - Consecutive coin pulses are therefore GAP_CYC+1 cycles apart.
- State WAIT_COLA: count cycles starting from 1.
  - po_cola high: go to DONE. err = 11 if po_money != chg_exp in that same cycle, else 00.
  - Count reaches TIMEOUT_CYC with no po_cola: go to DONE with err 10.
  - po_cola and the timeout in the same cycle: po_cola wins.
- State DONE (1 cycle): resp_valid = 1. resp_err and resp_used_* are valid this cycle and hold until the next accept. Then go to IDLE.
- po_cola / po_money outside WAIT_COLA are ignored.
- Wallet counts are 3-bit, so at most 7 of each coin. Counts never go below zero because of the CHECK gate.
- Illegal FSM state: recover to IDLE.

Optional Feature:
- Macro: COIN_PAYER_STAT_EN.
- Defined:
  - Adds outputs stat_cola (16-bit) and stat_change (16-bit).
  - stat_cola counts DONE cycles with err 00.
  - stat_change counts those with po_money seen.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package coin_payer_pkg holds:
  - state encoding: one-hot, IDLE/CHECK/INSERT/GAP/WAIT_COLA/DONE;
  - resp_err codes;
  - coin-select enum: NONE/HALF/ONE.
- One natural sub-module: coin_payer_sel.
  - Purely combinational.
  - Inputs: R and the remaining wallet.
  - Outputs: coin choice and next R.
  - Keeps the priority rule unit-testable.

Test Plan (default parameters; a model of the vending FSM drives po_cola/po_money one cycle after the coin that completes payment):
- Wallet one=2, half=1 → pulses one, one, half at t, t+3, t+6; po_cola at t+7, po_money 0; resp_err 00, used 2/1.
- Wallet one=3, half=0 → three one-yuan pulses; po_cola and po_money both high; resp_err 00, used 3/0.
- Wallet one=1, half=2 → no coin pulses; resp_valid two cycles after accept; resp_err 01, used 0/0.
- Wallet one=0, half=5 → five half pulses 3 cycles apart; resp_err 00, used 0/5.
- Wallet one=2, half=1 with the model suppressing po_cola → resp_valid after 8 WAIT_COLA cycles with err 10. Also, po_money high when chg_exp = 0 → err 11.
- Drop sys_rst_n during GAP → all outputs 0 immediately, req_ready 1, no resp_valid. The next request completes normally.

Source files
------------

// File: rtl/coin_payer_pkg.sv
// Shared types for the coin_payer customer-side vending driver: FSM state,
// response codes, coin selection and the wallet-value helper.
package coin_payer_pkg;

  localparam int OWED_W   = 5;
  localparam int WALLET_W = 3;

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_CHECK     = 6'b000010,
    ST_INSERT    = 6'b000100,
    ST_GAP       = 6'b001000,
    ST_WAIT_COLA = 6'b010000,
    ST_DONE      = 6'b100000
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_FUNDS   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_CHANGE  = 2'b11
  } resp_err_t;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_HALF = 2'd1,
    COIN_ONE  = 2'd2
  } coin_t;

  // Wallet worth in half-yuan units (max 2*7 + 7 = 21).
  function automatic logic [5:0] wallet_value(input logic [WALLET_W-1:0] one,
                                              input logic [WALLET_W-1:0] half);
    return {2'b00, one, 1'b0} + {3'b000, half};
  endfunction

endpackage

// File: rtl/coin_payer_sel.sv
// Coin choice for the next insertion: whole yuan while at least one yuan is
// owed, then halves, falling back to a whole yuan (overpay) when halves run out.
module coin_payer_sel
  import coin_payer_pkg::*;
(
  input  logic signed [OWED_W-1:0]   owed,
  input  logic        [WALLET_W-1:0] one_left,
  input  logic        [WALLET_W-1:0] half_left,
  output coin_t                      coin,
  output logic signed [OWED_W-1:0]   owed_next
);

  always_comb begin
    coin      = COIN_NONE;
    owed_next = owed;
    if (owed >= 5'sd2 && one_left != '0) begin
      coin      = COIN_ONE;
      owed_next = owed - 5'sd2;
    end else if (half_left != '0) begin
      coin      = COIN_HALF;
      owed_next = owed - 5'sd1;
    end else if (one_left != '0) begin
      coin      = COIN_ONE;
      owed_next = owed - 5'sd2;
    end
  end

endmodule

// File: rtl/coin_payer.sv
// Customer-side initiator for the cola vending FSM: pays PRICE_HALF from a
// latched wallet, then waits for the cola. Optional counters: COIN_PAYER_STAT_EN.
module coin_payer
  import coin_payer_pkg::*;
#(
  parameter int PRICE_HALF  = 5,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WALLET_W-1:0] req_one_num,
  input  logic [WALLET_W-1:0] req_half_num,
  input  logic                po_cola,
  input  logic                po_money,
  output logic                pi_money_one,
  output logic                pi_money_half,
  output logic                resp_valid,
  output logic [1:0]          resp_err,
  output logic [WALLET_W-1:0] resp_used_one,
  output logic [WALLET_W-1:0] resp_used_half
`ifdef COIN_PAYER_STAT_EN
  ,
  output logic [15:0]         stat_cola,
  output logic [15:0]         stat_change
`endif
);

  localparam logic signed [OWED_W-1:0] PRICE_OWED   = OWED_W'(PRICE_HALF);
  localparam logic        [5:0]        PRICE_VAL    = 6'(PRICE_HALF);
  localparam logic        [3:0]        GAP_LAST     = 4'(GAP_CYC);
  localparam logic        [7:0]        TIMEOUT_LAST = 8'(TIMEOUT_CYC);

  state_t                     state_q, state_d;
  logic signed [OWED_W-1:0]   owed_q;
  logic        [WALLET_W-1:0] one_left_q, half_left_q;
  logic        [WALLET_W-1:0] used_one_q, used_half_q;
  resp_err_t                  err_q;
  logic                       chg_exp_q;
  logic        [3:0]          gap_cnt_q;
  logic        [7:0]          wait_cnt_q;

  coin_t                      coin_sel;
  logic signed [OWED_W-1:0]   owed_sel;
  logic                       funds_short;

  coin_payer_sel u_sel (
    .owed      (owed_q),
    .one_left  (one_left_q),
    .half_left (half_left_q),
    .coin      (coin_sel),
    .owed_next (owed_sel)
  );

  assign funds_short = wallet_value(one_left_q, half_left_q) < PRICE_VAL;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req_valid) state_d = ST_CHECK;
      ST_CHECK:     state_d = funds_short ? ST_DONE : ST_INSERT;
      ST_INSERT:    state_d = (owed_sel <= 5'sd0) ? ST_WAIT_COLA : ST_GAP;
      ST_GAP:       if (gap_cnt_q >= GAP_LAST) state_d = ST_INSERT;
      ST_WAIT_COLA: if (po_cola || wait_cnt_q >= TIMEOUT_LAST) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Wallet, owed amount, counters and the held response
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      owed_q      <= '0;
      one_left_q  <= '0;
      half_left_q <= '0;
      used_one_q  <= '0;
      used_half_q <= '0;
      err_q       <= ERR_OK;
      chg_exp_q   <= 1'b0;
      gap_cnt_q   <= '0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          one_left_q  <= req_one_num;
          half_left_q <= req_half_num;
          owed_q      <= PRICE_OWED;
          used_one_q  <= '0;
          used_half_q <= '0;
          err_q       <= ERR_OK;
        end
        ST_CHECK: if (funds_short) err_q <= ERR_FUNDS;
        ST_INSERT: begin
          owed_q     <= owed_sel;
          chg_exp_q  <= (owed_sel < 5'sd0);
          gap_cnt_q  <= 4'd1;
          wait_cnt_q <= 8'd1;
          if (coin_sel == COIN_ONE) begin
            one_left_q <= one_left_q - 3'd1;
            used_one_q <= used_one_q + 3'd1;
          end else if (coin_sel == COIN_HALF) begin
            half_left_q <= half_left_q - 3'd1;
            used_half_q <= used_half_q + 3'd1;
          end
        end
        ST_GAP: gap_cnt_q <= gap_cnt_q + 4'd1;
        ST_WAIT_COLA: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (po_cola)
            err_q <= (po_money != chg_exp_q) ? ERR_CHANGE : ERR_OK;
          else if (wait_cnt_q >= TIMEOUT_LAST)
            err_q <= ERR_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    pi_money_one  = 1'b0;
    pi_money_half = 1'b0;
    resp_valid    = 1'b0;
    case (state_q)
      ST_IDLE:   req_ready = 1'b1;
      ST_INSERT: begin
        pi_money_one  = (coin_sel == COIN_ONE);
        pi_money_half = (coin_sel == COIN_HALF);
      end
      ST_DONE:   resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_err       = err_q;
  assign resp_used_one  = used_one_q;
  assign resp_used_half = used_half_q;

`ifdef COIN_PAYER_STAT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        money_seen_q;
  logic [15:0] stat_cola_q, stat_change_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      money_seen_q  <= 1'b0;
      stat_cola_q   <= '0;
      stat_change_q <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid)
        money_seen_q <= 1'b0;
      else if (state_q == ST_WAIT_COLA && po_cola)
        money_seen_q <= po_money;
      if (state_q == ST_DONE && err_q == ERR_OK) begin
        stat_cola_q <= sat_inc16(stat_cola_q);
        if (money_seen_q) stat_change_q <= sat_inc16(stat_change_q);
      end
    end
  end

  assign stat_cola   = stat_cola_q;
  assign stat_change = stat_change_q;
`endif

endmodule

// File: tb/tb_coin_payer.sv
// Directed bench for coin_payer with an inline vending-FSM model that answers
// po_cola/po_money one cycle after the coin that covers the price.
module tb_coin_payer;

  localparam int PRICE = 5;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_one_num = '0;
  logic [2:0] req_half_num = '0;
  logic       po_cola = 1'b0;
  logic       po_money = 1'b0;
  logic       pi_money_one, pi_money_half, resp_valid;
  logic [1:0] resp_err;
  logic [2:0] resp_used_one, resp_used_half;
`ifdef COIN_PAYER_STAT_EN
  logic [15:0] stat_cola, stat_change;
`endif

  coin_payer dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_one_num    (req_one_num),
    .req_half_num   (req_half_num),
    .po_cola        (po_cola),
    .po_money       (po_money),
    .pi_money_one   (pi_money_one),
    .pi_money_half  (pi_money_half),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_used_one  (resp_used_one),
    .resp_used_half (resp_used_half)
`ifdef COIN_PAYER_STAT_EN
    ,
    .stat_cola      (stat_cola),
    .stat_change    (stat_change)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Observations of one purchase; cycle 1 is the cycle after the accept edge.
  int         n_coins;
  int         coin_cyc[8];
  int         coin_kind[8];   // 1 = one yuan, 2 = half yuan
  int         resp_cyc;
  logic [1:0] obs_err;
  logic [2:0] obs_one, obs_half;
  bit         both_high, ready_during;
  logic       post_ready, post_valid;
  logic [1:0] post_err;

  task automatic run_purchase(input logic [2:0] one, input logic [2:0] half,
                              input int cola_delay, input bit force_money);
    int paid;
    int cola_cyc;
    n_coins = 0; resp_cyc = -1; both_high = 0; ready_during = 0;
    paid = 0; cola_cyc = -1;
    obs_err = 'x; obs_one = 'x; obs_half = 'x;
    @(negedge sys_clk);
    req_valid = 1'b1; req_one_num = one; req_half_num = half;
    @(negedge sys_clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge sys_clk);
      if (pi_money_one && pi_money_half) both_high = 1;
      if (req_ready) ready_during = 1;
      if (pi_money_one || pi_money_half) begin
        if (n_coins < 8) begin
          coin_cyc[n_coins]  = c;
          coin_kind[n_coins] = pi_money_one ? 1 : 2;
        end
        n_coins++;
        paid += pi_money_one ? 2 : 1;
        if (paid >= PRICE && cola_cyc < 0) cola_cyc = c + 1 + cola_delay;
      end
      po_cola  = (c == cola_cyc);
      po_money = po_cola && (force_money || paid > PRICE);
      if (resp_valid) begin
        resp_cyc = c; obs_err = resp_err; obs_one = resp_used_one; obs_half = resp_used_half;
        break;
      end
    end
    po_cola = 1'b0; po_money = 1'b0;
    @(negedge sys_clk);
    post_ready = req_ready; post_valid = resp_valid; post_err = resp_err;
  endtask

  task automatic test_reset();
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if ({pi_money_one, pi_money_half, resp_valid} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses got %b want 000", {pi_money_one, pi_money_half, resp_valid}); end
    checks++; if ({resp_err, resp_used_one, resp_used_half} !== 8'h00) begin errors++;
      $display("FAIL reset_resp got %h want 00", {resp_err, resp_used_one, resp_used_half}); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_exact_pay();
    int exp_cyc[3] = '{2, 5, 8};
    int exp_kind[3] = '{1, 1, 2};
    run_purchase(3'd2, 3'd1, 0, 1'b0);
    checks++; if (n_coins !== 3) begin errors++; $display("FAIL exact_ncoins got %0d want 3", n_coins); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (coin_cyc[i] !== exp_cyc[i] || coin_kind[i] !== exp_kind[i]) begin errors++;
        $display("FAIL exact_coin%0d got cyc %0d kind %0d want cyc %0d kind %0d", i, coin_cyc[i], coin_kind[i], exp_cyc[i], exp_kind[i]); end
    end
    checks++; if (resp_cyc !== 10) begin errors++; $display("FAIL exact_resp_cyc got %0d want 10", resp_cyc); end
    checks++; if ({obs_err, obs_one, obs_half} !== {2'b00, 3'd2, 3'd1}) begin errors++;
      $display("FAIL exact_resp got err %b used %0d/%0d want 00 2/1", obs_err, obs_one, obs_half); end
    checks++; if (both_high || ready_during) begin errors++;
      $display("FAIL exact_excl got both %0d ready %0d want 0 0", both_high, ready_during); end
    checks++; if ({post_ready, post_valid, post_err} !== 4'b1000) begin errors++;
      $display("FAIL exact_after got %b want 1000", {post_ready, post_valid, post_err}); end
  endtask

  task automatic test_overpay();
    run_purchase(3'd3, 3'd0, 0, 1'b0);
    checks++; if (n_coins !== 3 || coin_kind[2] !== 1 || coin_cyc[2] !== 8) begin errors++;
      $display("FAIL over_coins got n %0d kind %0d cyc %0d want 3 1 8", n_coins, coin_kind[2], coin_cyc[2]); end
    checks++; if (resp_cyc !== 10 || {obs_err, obs_one, obs_half} !== {2'b00, 3'd3, 3'd0}) begin errors++;
      $display("FAIL over_resp got cyc %0d err %b used %0d/%0d want 10 00 3/0", resp_cyc, obs_err, obs_one, obs_half); end
  endtask

  task automatic test_insufficient();
    run_purchase(3'd1, 3'd2, 0, 1'b0);
    checks++; if (n_coins !== 0 || resp_cyc !== 2) begin errors++;
      $display("FAIL funds_timing got coins %0d cyc %0d want 0 2", n_coins, resp_cyc); end
    checks++; if ({obs_err, obs_one, obs_half} !== {2'b01, 3'd0, 3'd0}) begin errors++;
      $display("FAIL funds_resp got err %b used %0d/%0d want 01 0/0", obs_err, obs_one, obs_half); end
    run_purchase(3'd2, 3'd0, 0, 1'b0);
    checks++; if (n_coins !== 0 || resp_cyc !== 2 || obs_err !== 2'b01) begin errors++;
      $display("FAIL funds_edge got coins %0d cyc %0d err %b want 0 2 01", n_coins, resp_cyc, obs_err); end
  endtask

  task automatic test_half_only();
    run_purchase(3'd0, 3'd5, 0, 1'b0);
    checks++; if (n_coins !== 5 || coin_cyc[1] !== 5 || coin_cyc[4] !== 14) begin errors++;
      $display("FAIL half_coins got n %0d c1 %0d c4 %0d want 5 5 14", n_coins, coin_cyc[1], coin_cyc[4]); end
    checks++; if (coin_kind[0] !== 2 || coin_kind[4] !== 2) begin errors++;
      $display("FAIL half_kind got %0d %0d want 2 2", coin_kind[0], coin_kind[4]); end
    checks++; if (resp_cyc !== 16 || {obs_err, obs_one, obs_half} !== {2'b00, 3'd0, 3'd5}) begin errors++;
      $display("FAIL half_resp got cyc %0d err %b used %0d/%0d want 16 00 0/5", resp_cyc, obs_err, obs_one, obs_half); end
  endtask

  task automatic test_priority();
    int exp_kind[4] = '{1, 2, 2, 2};
    run_purchase(3'd1, 3'd3, 0, 1'b0);
    checks++; if (n_coins !== 4) begin errors++; $display("FAIL prio_ncoins got %0d want 4", n_coins); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (coin_kind[i] !== exp_kind[i]) begin errors++;
        $display("FAIL prio_kind%0d got %0d want %0d", i, coin_kind[i], exp_kind[i]); end
    end
    checks++; if (resp_cyc !== 13 || {obs_err, obs_one, obs_half} !== {2'b00, 3'd1, 3'd3}) begin errors++;
      $display("FAIL prio_resp got cyc %0d err %b used %0d/%0d want 13 00 1/3", resp_cyc, obs_err, obs_one, obs_half); end
  endtask

  task automatic test_timeout();
    run_purchase(3'd2, 3'd1, 100, 1'b0);
    checks++; if (resp_cyc !== 17 || obs_err !== 2'b10) begin errors++;
      $display("FAIL tmo_none got cyc %0d err %b want 17 10", resp_cyc, obs_err); end
    checks++; if ({obs_one, obs_half} !== {3'd2, 3'd1}) begin errors++;
      $display("FAIL tmo_used got %0d/%0d want 2/1", obs_one, obs_half); end
    run_purchase(3'd2, 3'd1, 7, 1'b0);
    checks++; if (resp_cyc !== 17 || obs_err !== 2'b00) begin errors++;
      $display("FAIL tmo_cola_last got cyc %0d err %b want 17 00", resp_cyc, obs_err); end
    run_purchase(3'd2, 3'd1, 8, 1'b0);
    checks++; if (resp_cyc !== 17 || obs_err !== 2'b10) begin errors++;
      $display("FAIL tmo_cola_late got cyc %0d err %b want 17 10", resp_cyc, obs_err); end
  endtask

  task automatic test_change_mismatch();
    run_purchase(3'd2, 3'd1, 0, 1'b1);
    checks++; if (resp_cyc !== 10 || obs_err !== 2'b11) begin errors++;
      $display("FAIL chg_mismatch got cyc %0d err %b want 10 11", resp_cyc, obs_err); end
  endtask

  task automatic test_reset_mid();
    bit saw_resp;
    saw_resp = 0;
    @(negedge sys_clk);
    req_valid = 1'b1; req_one_num = 3'd2; req_half_num = 3'd1;
    @(negedge sys_clk);
    req_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || {pi_money_one, pi_money_half, resp_valid} !== 3'b000) begin errors++;
      $display("FAIL midrst_ctrl got ready %b pulses %b want 1 000", req_ready, {pi_money_one, pi_money_half, resp_valid}); end
    checks++; if ({resp_err, resp_used_one, resp_used_half} !== 8'h00) begin errors++;
      $display("FAIL midrst_resp got %h want 00", {resp_err, resp_used_one, resp_used_half}); end
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if (resp_valid) saw_resp = 1;
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      if (resp_valid) saw_resp = 1;
    end
    checks++; if (saw_resp) begin errors++; $display("FAIL midrst_noresp got 1 want 0"); end
    run_purchase(3'd2, 3'd1, 0, 1'b0);
    checks++; if (resp_cyc !== 10 || {obs_err, obs_one, obs_half} !== {2'b00, 3'd2, 3'd1}) begin errors++;
      $display("FAIL midrst_next got cyc %0d err %b used %0d/%0d want 10 00 2/1", resp_cyc, obs_err, obs_one, obs_half); end
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_overpay();
    test_insufficient();
    test_half_only();
    test_priority();
    test_timeout();
    test_change_mismatch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
